// File: rtl/palette_pkg.sv
// Shared types for the sprite palette engine.
//   rgb_t          : one 24-bit palette entry, {r, g, b}
//   commit_state_t : shadow->active commit FSM state
//   clog2_min1     : address width helper that never returns 0
package palette_pkg;

  localparam int RGB_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/palette_bank.sv
// One palette table: a software-written shadow copy and the active copy that
// the pixel pipeline reads. A copy strobe moves every shadow entry to active in
// one cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears both copies)
//   wr_en      : write shadow[wr_index] <= wr_rgb (out-of-range index ignored)
//   copy_en    : active <= shadow (pre-write shadow contents)
//   rd_index   : combinational read address into the active copy
//   rd_rgb     : active[rd_index], or 0 when rd_index is out of range
module palette_bank
  import palette_pkg::*;
#(
  parameter int NUM_COLORS = 16,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  rgb_t             wr_rgb,
  input  logic             copy_en,
  input  logic [IDX_W-1:0] rd_index,
  output rgb_t             rd_rgb
);

  rgb_t shadow_q [NUM_COLORS];
  rgb_t shadow_d [NUM_COLORS];
  rgb_t active_q [NUM_COLORS];
  rgb_t active_d [NUM_COLORS];

  // The copy reads shadow_q, so a write landing in the same cycle reaches
  // the shadow only and waits for the next commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (copy_en) begin
      active_d = shadow_q;
    end
    if (wr_en && (int'(wr_index) < NUM_COLORS)) begin
      shadow_d[wr_index] = wr_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    rd_rgb = '0;
    if (int'(rd_index) < NUM_COLORS) begin
      rd_rgb = active_q[rd_index];
    end
  end

endmodule

// File: rtl/sprite_palette_engine.sv
// Writable, double-buffered sprite palette lookup.
// NUM_PALETTES tables of NUM_COLORS RGB entries; a (palette, index) request is
// turned into Red/Green/Blue two cycles later, one pixel per cycle.
// Software writes shadow tables; a commit copies all shadows to the active
// tables atomically at the next frame_start.
// Ports:
//   Clk, Reset_n                         : clock, synchronous active-low reset
//   pix_valid, pix_palette, pix_index    : lookup request
//   out_valid, Red, Green, Blue,
//   out_transparent                      : lookup result, latency 2
//   wr_en, wr_palette, wr_index, wr_rgb  : shadow entry write
//   commit_req, frame_start              : commit request / vertical blank pulse
//   commit_pending                       : commit FSM is in PENDING
// Handshake: no backpressure. pix_valid is taken every cycle it is high and
// out_valid is exactly pix_valid delayed by two cycles; outputs hold their
// last value while out_valid is low.
module sprite_palette_engine
  import palette_pkg::*;
#(
  parameter  int NUM_PALETTES   = 4,
  parameter  int NUM_COLORS     = 16,
  parameter  int TRANSPARENT_EN = 1,
  localparam int PAL_W          = clog2_min1(NUM_PALETTES),
  localparam int IDX_W          = clog2_min1(NUM_COLORS)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             pix_valid,
  input  logic [PAL_W-1:0] pix_palette,
  input  logic [IDX_W-1:0] pix_index,
  output logic             out_valid,
  output logic [7:0]       Red,
  output logic [7:0]       Green,
  output logic [7:0]       Blue,
  output logic             out_transparent,
  input  logic             wr_en,
  input  logic [PAL_W-1:0] wr_palette,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [RGB_W-1:0] wr_rgb,
  input  logic             commit_req,
  input  logic             frame_start,
  output logic             commit_pending
);

  // ---------------- commit FSM ----------------
  commit_state_t state_q, state_d;
  logic          copy_en;

  always_comb begin
    state_d = state_q;
    copy_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req) begin
          if (frame_start) begin
            copy_en = 1'b1;
          end else begin
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        // A repeated commit_req here is simply absorbed.
        if (frame_start) begin
          copy_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign commit_pending = (state_q == PENDING);

  // ---------------- palette banks ----------------
  logic [NUM_PALETTES-1:0] bank_wr_en;
  rgb_t                    bank_rgb [NUM_PALETTES];

  // Out-of-range wr_palette matches no bank, so the write is dropped.
  always_comb begin
    bank_wr_en = '0;
    for (int p = 0; p < NUM_PALETTES; p++) begin
      bank_wr_en[p] = wr_en && (int'(wr_palette) == p);
    end
  end

  // ---------------- stage 1: request register ----------------
  logic             s1_valid_q,   s1_valid_d;
  logic [PAL_W-1:0] s1_palette_q, s1_palette_d;
  logic [IDX_W-1:0] s1_index_q,   s1_index_d;

  always_comb begin
    s1_valid_d   = pix_valid;
    s1_palette_d = pix_palette;
    s1_index_d   = pix_index;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_palette_q <= '0;
      s1_index_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_palette_q <= s1_palette_d;
      s1_index_q   <= s1_index_d;
    end
  end

  for (genvar gp = 0; gp < NUM_PALETTES; gp++) begin : g_bank
    palette_bank #(
      .NUM_COLORS (NUM_COLORS),
      .IDX_W      (IDX_W)
    ) u_bank (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .wr_en    (bank_wr_en[gp]),
      .wr_index (wr_index),
      .wr_rgb   (rgb_t'(wr_rgb)),
      .copy_en  (copy_en),
      .rd_index (s1_index_q),
      .rd_rgb   (bank_rgb[gp])
    );
  end

  // ---------------- stage 2: select, range/transparency, output register ----
  rgb_t lookup_rgb;
  logic lookup_transp;

  // Select by comparison rather than indexing so an out-of-range palette
  // yields 0 instead of an undefined array read.
  always_comb begin
    lookup_rgb = '0;
    for (int p = 0; p < NUM_PALETTES; p++) begin
      if (int'(s1_palette_q) == p) begin
        lookup_rgb = bank_rgb[p];
      end
    end
    lookup_transp = (int'(s1_palette_q) >= NUM_PALETTES) ||
                    (int'(s1_index_q) >= NUM_COLORS) ||
                    ((TRANSPARENT_EN != 0) && (s1_index_q == '0));
  end

  logic out_valid_q, out_valid_d;
  rgb_t rgb_q,       rgb_d;
  logic transp_q,    transp_d;

  always_comb begin
    out_valid_d = s1_valid_q;
    rgb_d       = rgb_q;
    transp_d    = transp_q;
    if (s1_valid_q) begin
      transp_d = lookup_transp;
      rgb_d    = lookup_transp ? '0 : lookup_rgb;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
      transp_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      rgb_q       <= rgb_d;
      transp_q    <= transp_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign Red             = rgb_q.r;
  assign Green           = rgb_q.g;
  assign Blue            = rgb_q.b;
  assign out_transparent = transp_q;

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Bench for sprite_palette_engine: a default 4x16 instance (dut) and a
// 3-palette instance (dut3) sharing write/commit inputs, each with its own
// pix_valid. Every pixel issued pushes {due_cycle, transparent, rgb} into an
// expected queue; the per-cycle monitor pops and compares on out_valid.
module tb_sprite_palette_engine;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_valid, pix_valid3;
  logic [1:0]  pix_palette;
  logic [3:0]  pix_index;
  logic        wr_en;
  logic [1:0]  wr_palette;
  logic [3:0]  wr_index;
  logic [23:0] wr_rgb;
  logic        commit_req, frame_start;

  logic        out_valid, out_transparent, commit_pending;
  logic [7:0]  Red, Green, Blue;
  logic        out_valid3, out_transparent3, commit_pending3;
  logic [7:0]  Red3, Green3, Blue3;

  always #5 Clk = ~Clk;

  sprite_palette_engine dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid(pix_valid), .pix_palette(pix_palette), .pix_index(pix_index),
    .out_valid(out_valid), .Red(Red), .Green(Green), .Blue(Blue),
    .out_transparent(out_transparent),
    .wr_en(wr_en), .wr_palette(wr_palette), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .commit_req(commit_req), .frame_start(frame_start),
    .commit_pending(commit_pending)
  );

  sprite_palette_engine #(.NUM_PALETTES(3)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid(pix_valid3), .pix_palette(pix_palette), .pix_index(pix_index),
    .out_valid(out_valid3), .Red(Red3), .Green(Green3), .Blue(Blue3),
    .out_transparent(out_transparent3),
    .wr_en(wr_en), .wr_palette(wr_palette), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .commit_req(commit_req), .frame_start(frame_start),
    .commit_pending(commit_pending3)
  );

  typedef struct {
    logic [1:0]  pal;
    logic [3:0]  idx;
    logic [23:0] rgb;
    logic        tr;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic neg_done = 1'b0;
  logic [40:0] exp_q[$];
  logic [40:0] exp3_q[$];

  function automatic logic [23:0] pal1_val(input int i);
    return {8'(i * 16 + 1), 8'(32 + i), 8'(255 - i)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_one(input string nm, input logic ov, input logic [24:0] act,
                         inout logic [40:0] q[$]);
    logic [40:0] e;
    if (ov) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL %s_unexpected: out_valid=1 at cyc %0d, none expected", nm, cyc);
      end else begin
        e = q.pop_front();
        if (act !== e[24:0] || int'(e[40:25]) != cyc) begin
          bad++;
          $display("FAIL %s_pix: got tr=%b rgb=%h at cyc %0d want tr=%b rgb=%h at cyc %0d",
                   nm, act[24], act[23:0], cyc, e[24], e[23:0], e[40:25]);
        end
      end
    end else if (q.size() != 0 && int'(q[0][40:25]) <= cyc) begin
      total++;
      bad++;
      e = q.pop_front();
      $display("FAIL %s_missing: out_valid=0 at cyc %0d want rgb=%h", nm, cyc, e[23:0]);
    end
  endtask

  task automatic neg();
    @(negedge Clk);
    mon_one("dut", out_valid, {out_transparent, Red, Green, Blue}, exp_q);
    mon_one("dut3", out_valid3, {out_transparent3, Red3, Green3, Blue3}, exp3_q);
    neg_done = 1'b1;
  endtask

  task automatic step();
    if (!neg_done) neg();
    @(posedge Clk);
    #1;
    cyc++;
    neg_done    = 1'b0;
    pix_valid   = 1'b0;
    pix_valid3  = 1'b0;
    wr_en       = 1'b0;
    commit_req  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic lookup(input logic [1:0] pal, input logic [3:0] idx,
                        input logic [23:0] rgb, input logic tr);
    pix_valid   = 1'b1;
    pix_palette = pal;
    pix_index   = idx;
    exp_q.push_back({16'(cyc + 2), tr, rgb});
  endtask

  task automatic lookup3(input logic [23:0] rgb, input logic tr);
    pix_valid3 = 1'b1;
    exp3_q.push_back({16'(cyc + 2), tr, rgb});
  endtask

  task automatic wr(input logic [1:0] pal, input logic [3:0] idx, input logic [23:0] rgb);
    wr_en      = 1'b1;
    wr_palette = pal;
    wr_index   = idx;
    wr_rgb     = rgb;
    step();
  endtask

  task automatic commit_now();
    commit_req  = 1'b1;
    frame_start = 1'b1;
    step();
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'd0, 4'd0,  24'h000000, 1'b1};
    vecs[1] = '{2'd0, 4'd7,  24'h123456, 1'b0};
    vecs[2] = '{2'd1, 4'd3,  24'h8d715a, 1'b0};
    vecs[3] = '{2'd1, 4'd15, 24'hF12FF0, 1'b0};
    vecs[4] = '{2'd2, 4'd5,  24'hd8edfa, 1'b0};
    vecs[5] = '{2'd2, 4'd0,  24'h000000, 1'b1};
    vecs[6] = '{2'd3, 4'd5,  24'h000000, 1'b0};
    vecs[7] = '{2'd1, 4'd5,  24'h5125FA, 1'b0};

    Reset_n = 1'b0;
    pix_valid = 0; pix_valid3 = 0; pix_palette = 0; pix_index = 0;
    wr_en = 0; wr_palette = 0; wr_index = 0; wr_rgb = 0;
    commit_req = 0; frame_start = 0;
    step();
    step();
    neg();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_rgb", {8'h0, Red, Green, Blue}, 0);
    check("rst_transp", 32'(out_transparent), 0);
    check("rst_pending", 32'(commit_pending), 0);
    check("rst_pending3", 32'(commit_pending3), 0);
    Reset_n = 1'b1;
    step();

    // First lookup after reset: zero colour, not transparent, latency 2.
    lookup(2'd1, 4'd3, 24'h0, 1'b0);
    step();
    drain();

    // Deferred commit: pending until the frame_start edge; boundary lookups.
    wr(2'd1, 4'd3, 24'h8d715a);
    commit_req = 1'b1;
    neg();
    check("pend_before_req", 32'(commit_pending), 0);
    step();
    for (int i = 1; i <= 4; i++) begin
      if (i == 1 || i == 4) lookup(2'd1, 4'd3, 24'h0, 1'b0);
      neg();
      check("pend_waiting", 32'(commit_pending), 1);
      step();
    end
    frame_start = 1'b1;
    lookup(2'd1, 4'd3, 24'h8d715a, 1'b0);
    neg();
    check("pend_at_fs", 32'(commit_pending), 1);
    step();
    neg();
    check("pend_after_fs", 32'(commit_pending), 0);
    drain();
    neg();
    check("hold_valid", 32'(out_valid), 0);
    check("hold_rgb", {8'h0, Red, Green, Blue}, 32'h008d715a);

    // Back-to-back 16 lookups on palette 1.
    for (int i = 0; i < 16; i++) begin
      if (i != 3) wr(2'd1, 4'(i), pal1_val(i));
    end
    commit_now();
    neg();
    check("pend_imm_commit", 32'(commit_pending), 0);
    for (int i = 0; i < 16; i++) begin
      lookup(2'd1, 4'(i), (i == 0) ? 24'h0 : ((i == 3) ? 24'h8d715a : pal1_val(i)), i == 0);
      step();
    end
    drain();

    // Write coinciding with immediate copy lands in shadow only.
    wr_en = 1'b1; wr_palette = 2'd2; wr_index = 4'd5; wr_rgb = 24'hd8edfa;
    commit_req = 1'b1; frame_start = 1'b1;
    step();
    neg();
    check("pend_wr_copy", 32'(commit_pending), 0);
    lookup(2'd2, 4'd5, 24'h0, 1'b0);
    step();
    drain();
    commit_now();
    lookup(2'd2, 4'd5, 24'hd8edfa, 1'b0);
    step();
    drain();

    // frame_start alone does nothing; repeated commit_req is absorbed.
    wr(2'd0, 4'd7, 24'h123456);
    frame_start = 1'b1;
    step();
    neg();
    check("fs_no_pending", 32'(commit_pending), 0);
    lookup(2'd0, 4'd7, 24'h0, 1'b0);
    step();
    commit_req = 1'b1;
    step();
    commit_req = 1'b1;
    neg();
    check("pend_first_req", 32'(commit_pending), 1);
    step();
    neg();
    check("pend_absorbed", 32'(commit_pending), 1);
    frame_start = 1'b1;
    step();
    neg();
    check("pend_cleared", 32'(commit_pending), 0);
    lookup(2'd0, 4'd7, 24'h123456, 1'b0);
    step();
    step();
    neg();
    check("no_rearm", 32'(commit_pending), 0);
    drain();

    // Table-driven mixed lookups, back to back.
    for (int i = 0; i < 8; i++) begin
      lookup(vecs[i].pal, vecs[i].idx, vecs[i].rgb, vecs[i].tr);
      step();
    end
    drain();

    // Three-palette instance: palette 3 out of range, writes to it ignored.
    wr(2'd3, 4'd2, 24'habcdef);
    wr(2'd2, 4'd2, 24'h112233);
    commit_now();
    lookup(2'd3, 4'd2, 24'habcdef, 1'b0); lookup3(24'h0, 1'b1); step();
    lookup(2'd2, 4'd2, 24'h112233, 1'b0); lookup3(24'h112233, 1'b0); step();
    lookup(2'd1, 4'd3, 24'h8d715a, 1'b0); lookup3(24'h8d715a, 1'b0); step();
    lookup(2'd3, 4'd0, 24'h0, 1'b1);      lookup3(24'h0, 1'b1); step();
    lookup(2'd0, 4'd7, 24'h123456, 1'b0); lookup3(24'h123456, 1'b0); step();
    drain();

    // One-cycle reset with two pixels in flight and a pending commit.
    wr(2'd0, 4'd1, 24'h777777);
    commit_req = 1'b1;
    step();
    neg();
    check("pend_pre_rst", 32'(commit_pending), 1);
    pix_valid = 1'b1; pix_palette = 2'd1; pix_index = 4'd3;
    step();
    pix_valid = 1'b1; pix_palette = 2'd1; pix_index = 4'd5;
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    neg();
    check("rst_drop1", 32'(out_valid), 0);
    check("rst_pend_clr", 32'(commit_pending), 0);
    check("rst_pend_clr3", 32'(commit_pending3), 0);
    check("rst_rgb_clr", {7'h0, out_transparent, Red, Green, Blue}, 0);
    step();
    neg();
    check("rst_drop2", 32'(out_valid), 0);
    step();
    lookup(2'd1, 4'd3, 24'h0, 1'b0); step();
    lookup(2'd0, 4'd7, 24'h0, 1'b0); step();
    frame_start = 1'b1;
    step();
    commit_now();
    lookup(2'd0, 4'd1, 24'h0, 1'b0); step();
    lookup(2'd2, 4'd5, 24'h0, 1'b0); step();
    lookup(2'd1, 4'd15, 24'h0, 1'b0); step();
    drain();

    check("exp_q_empty", 32'(exp_q.size()), 0);
    check("exp3_q_empty", 32'(exp3_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
